carrier_start_sequencer: RTL
============================

# carrier_start_sequencer

Run-control sequencer for a bank of carrier channels. It turns each channel's `pwm_onoff` on in ascending index order, with a programmable stagger delay between enabled channels. On stop, it turns each channel off only after that channel's own `maskevent`, so a carrier is never cut mid-period. It sits between the AXI register bank and the per-channel carrier/PWM blocks, and replaces direct software writes of `pwm_onoff`.

## Interface
Parameters:
- `N_CARR`, 8, number of carrier channels controlled.
- `DLY_WIDTH`, 16, width of the stagger and timeout counters.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, same domain as the carrier blocks.
- `reset`  in  1  synchronous, active-high; forces IDLE and clears all outputs.
- `start_req`  in  1  single-cycle start request.
- `stop_req`  in  1  single-cycle stop request.
- `chan_mask`  in  N_CARR  channels to start; sampled on an accepted start.
- `stagger_dly`  in  DLY_WIDTH  extra cycles between enabled channels; sampled on an accepted start.
- `drain_timeout`  in  DLY_WIDTH  maximum DRAIN cycles before a forced stop; 0 disables the timeout; sampled on an accepted stop.
- `maskevent`  in  N_CARR  per-channel mask event from each channel's event counter.
- `pwm_onoff`  out  N_CARR  registered per-channel enable.
- `busy`  out  1  high in any state other than IDLE.
- `running`  out  1  high in RUN only.
- `done`  out  1  one-cycle pulse on the DRAIN->IDLE transition.
- `fault`  out  1  sticky flag, set by a drain timeout.

## Operation
- FSM states: IDLE, STAGGER, RUN, DRAIN.
- **IDLE**
  - Accept `start_req` only if `chan_mask != 0`.
  - On accept: latch `chan_mask` and `stagger_dly`, set idx=0 and cnt=0, clear `fault`, go to STAGGER.
  - `start_req` with `chan_mask == 0` is ignored.
  - `stop_req` is ignored.
  - If `start_req` and `stop_req` arrive in the same cycle, stop wins and nothing happens.
- **STAGGER**
  - Each idx is evaluated in order.
  - If the latched mask bit is 0, idx advances after 1 cycle.
  - If the bit is 1: on the first cycle of this idx, set `pwm_onoff[idx]`. The idx then occupies `stagger_dly`+1 cycles in total before advancing.
  - After idx = N_CARR-1 is processed, go to RUN.
  - `stop_req` goes to DRAIN immediately; channels not yet enabled stay off.
- **RUN**
  - `pwm_onoff` is held.
  - `stop_req` latches `drain_timeout`, clears the timeout counter and goes to DRAIN.
  - `start_req` is ignored.
- **DRAIN**
  - For each k with `pwm_onoff[k]`=1 and `maskevent[k]`=1, clear `pwm_onoff[k]` on the next edge.
  - When `pwm_onoff` is all zero: go to IDLE and pulse `done`.
  - If `drain_timeout` is nonzero and the counter reaches it: clear all `pwm_onoff`, set `fault`, go to IDLE and pulse `done`.
  - `start_req` and `stop_req` are ignored.
  - If DRAIN is entered with all channels already off, go to IDLE on the next cycle.
- Counters saturate; they never wrap. `stagger_dly` = 0 gives one enabled channel per cycle.
- Reset in any state: IDLE, all outputs 0, idx, cnt and latches cleared.

## Timing
- Reset values: `pwm_onoff`=0, `busy`=0, `running`=0, `done`=0, `fault`=0.
- All outputs are registered. There is no combinational path from input to output.
- Start sampled at cycle t gives STAGGER at t+1, with `busy`=1 at t+1.
  - The first enabled channel at idx i has `pwm_onoff` high at t+2+i (for i < first enabled index, each disabled channel costs 1 cycle).
  - Successive enabled channels rise `stagger_dly`+1 cycles apart, plus 1 cycle per disabled channel in between.
- `maskevent[k]` high at cycle m in DRAIN gives `pwm_onoff[k]` low at m+1.
- The last channel clearing at cycle c gives state IDLE and `done`=1 at c+1, with `busy`=0 at c+1.
- Timeout: counter incremented on every DRAIN cycle; the forced clear lands `drain_timeout` cycles after DRAIN entry.

## Structure
- Shared package `PKG_pwm` holds:
  - `typedef enum _seq_state {IDLE, STAGGER, RUN, DRAIN}`.
  - The `N_CARR` default constant, reusing `` `PWMCOUNT_WIDTH `` for `DLY_WIDTH`.
- One natural sub-module: `seq_delay_counter`, a loadable saturating down-counter with a zero flag. It is used twice, once for the stagger delay and once for the drain timeout.
- Per-channel drain logic is a generate loop inside the top module.

## Test plan
- N_CARR=4, `chan_mask`=4'b0101, `stagger_dly`=3, start at t -> `pwm_onoff[0]` rises at t+2, `[2]` rises at t+7, `running`=1 at t+11, `[1]` and `[3]` stay 0.
- From RUN with channels 0 and 2 on: stop, then `maskevent[2]` at m1 and `maskevent[0]` at m2>m1 -> bit 2 falls at m1+1, bit 0 falls at m2+1, `done` pulses at m2+2, `busy` falls at m2+2.
- Stop during STAGGER after only channel 0 is on, with `drain_timeout`=0 -> channel 2 never rises; after `maskevent[0]`, return to IDLE.
- `drain_timeout`=10 and no `maskevent` -> all `pwm_onoff` clear 10 cycles after DRAIN entry; `fault`=1 and `done` pulse; `fault` clears on the next accepted start.
- Edge cases:
  - `start_req` with `chan_mask`=0 -> stays in IDLE.
  - Simultaneous start and stop in IDLE -> stays in IDLE.
  - `start_req` in RUN -> ignored.
  - `stagger_dly`=0 with a full mask -> channels rise on consecutive cycles.
- Synchronous reset asserted mid-STAGGER and mid-DRAIN -> next cycle: all outputs 0, state IDLE; a new start then behaves exactly as from power-up.

Source files
------------

// File: rtl/carrier_start_sequencer_pkg.sv
// Shared definitions for the carrier run-control sequencer: state encoding,
// default sizing and a small width helper.
package carrier_start_sequencer_pkg;

  // Width of the carrier period counters; the sequencer delays reuse it.
  localparam int PWMCOUNT_WIDTH = 16;

  localparam int N_CARR_DEFAULT    = 8;
  localparam int DLY_WIDTH_DEFAULT = PWMCOUNT_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    STAGGER,
    RUN,
    DRAIN
  } seq_state_e;

  // Index register width for a channel count, never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/carrier_start_sequencer_if.sv
// Control/status bundle between the register bank (master) and the
// sequencer (slave). The carrier maskevent lines ride along as inputs.
interface carrier_start_sequencer_if
  import carrier_start_sequencer_pkg::*;
#(
  parameter int N_CARR    = N_CARR_DEFAULT,
  parameter int DLY_WIDTH = DLY_WIDTH_DEFAULT
) ();

  logic                 start_req;
  logic                 stop_req;
  logic [N_CARR-1:0]    chan_mask;
  logic [DLY_WIDTH-1:0] stagger_dly;
  logic [DLY_WIDTH-1:0] drain_timeout;
  logic [N_CARR-1:0]    maskevent;

  logic [N_CARR-1:0]    pwm_onoff;
  logic                 busy;
  logic                 running;
  logic                 done;
  logic                 fault;

  modport master (
    output start_req, stop_req, chan_mask, stagger_dly, drain_timeout, maskevent,
    input  pwm_onoff, busy, running, done, fault
  );

  modport slave (
    input  start_req, stop_req, chan_mask, stagger_dly, drain_timeout, maskevent,
    output pwm_onoff, busy, running, done, fault
  );

endinterface

// File: rtl/seq_delay_counter.sv
// Loadable saturating down-counter with a zero flag. Used for both the
// per-channel stagger delay and the drain timeout.
module seq_delay_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load has priority; decrementing stops at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/carrier_start_sequencer.sv
// Run-control sequencer: enables carrier channels in ascending order with a
// programmable stagger, and on stop releases each channel only at its own
// maskevent so no carrier period is cut short.
module carrier_start_sequencer
  import carrier_start_sequencer_pkg::*;
#(
  parameter int N_CARR    = N_CARR_DEFAULT,
  parameter int DLY_WIDTH = DLY_WIDTH_DEFAULT
) (
  input logic clk,
  input logic reset,
  carrier_start_sequencer_if.slave bus
);

  localparam int IDX_W = idx_width(N_CARR);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CARR - 1);

  seq_state_e           state;
  logic [IDX_W-1:0]     idx;
  logic                 first;
  logic [N_CARR-1:0]    mask_q;
  logic [DLY_WIDTH-1:0] dly_q;
  logic                 tmo_en_q;

  logic [N_CARR-1:0]    pwm_q;
  logic                 busy_q;
  logic                 running_q;
  logic                 done_q;
  logic                 fault_q;

  logic                 start_ok;
  logic                 stop_accept;
  logic                 cur_bit;
  logic                 stag_last;
  logic                 stag_load;
  logic [DLY_WIDTH-1:0] stag_load_val;
  logic                 stag_dec;
  logic                 stag_zero;
  logic                 tmo_load;
  logic [DLY_WIDTH-1:0] tmo_load_val;
  logic                 tmo_dec;
  logic                 tmo_zero;
  logic [N_CARR-1:0]    drain_clr;

  // Decode counter controls and step conditions from the current state.
  // A stagger slot of dly+1 cycles is: one enabling cycle, then dly-1 loaded
  // into the counter and the slot ends on the cycle it reads zero.
  always_comb begin
    start_ok      = bus.start_req && !bus.stop_req && (bus.chan_mask != '0);
    stop_accept   = bus.stop_req && ((state == STAGGER) || (state == RUN));
    cur_bit       = mask_q[idx];
    stag_last     = !cur_bit || (first ? (dly_q == '0) : stag_zero);
    stag_load     = 1'b0;
    stag_load_val = '0;
    if ((state == IDLE) && start_ok) begin
      stag_load = 1'b1;
    end else if ((state == STAGGER) && !bus.stop_req && first && cur_bit) begin
      stag_load     = 1'b1;
      stag_load_val = dly_q - DLY_WIDTH'(1);
    end
    stag_dec     = (state == STAGGER) && !first;
    tmo_load     = stop_accept;
    tmo_load_val = (bus.drain_timeout == '0) ? '0 : bus.drain_timeout - DLY_WIDTH'(1);
    tmo_dec      = (state == DRAIN);
  end

  seq_delay_counter #(.WIDTH(DLY_WIDTH)) u_stagger_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (stag_load),
    .load_val (stag_load_val),
    .dec      (stag_dec),
    .zero     (stag_zero)
  );

  seq_delay_counter #(.WIDTH(DLY_WIDTH)) u_timeout_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (tmo_load),
    .load_val (tmo_load_val),
    .dec      (tmo_dec),
    .zero     (tmo_zero)
  );

  // A channel may be released only while it is on and its carrier reports a mask event.
  for (genvar k = 0; k < N_CARR; k++) begin : g_drain
    assign drain_clr[k] = pwm_q[k] & bus.maskevent[k];
  end

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      first     <= 1'b0;
      mask_q    <= '0;
      dly_q     <= '0;
      tmo_en_q  <= 1'b0;
      pwm_q     <= '0;
      busy_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            mask_q  <= bus.chan_mask;
            dly_q   <= bus.stagger_dly;
            idx     <= '0;
            first   <= 1'b1;
            fault_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= STAGGER;
          end
        end
        STAGGER: begin
          if (bus.stop_req) begin
            tmo_en_q <= (bus.drain_timeout != '0);
            state    <= DRAIN;
          end else begin
            if (first && cur_bit) begin
              pwm_q[idx] <= 1'b1;
            end
            if (stag_last) begin
              first <= 1'b1;
              if (idx == LAST_IDX) begin
                running_q <= 1'b1;
                state     <= RUN;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              first <= 1'b0;
            end
          end
        end
        RUN: begin
          if (bus.stop_req) begin
            tmo_en_q  <= (bus.drain_timeout != '0);
            running_q <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (pwm_q == '0) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else if (tmo_en_q && tmo_zero) begin
            pwm_q   <= '0;
            fault_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= IDLE;
          end else begin
            pwm_q <= pwm_q & ~drain_clr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pwm_onoff = pwm_q;
  assign bus.busy      = busy_q;
  assign bus.running   = running_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;

endmodule
